drift_corr_apply: RTL and testbench
===================================

# drift_corr_apply

Consumer side of the drift-gain calculation. Latches the four per-channel IEEE-754 single-precision gain corrections whenever the drift block pulses its ready strobe, then multiplies each incoming frame of four channel powers by those corrections. Each frame is multiplied sequentially through one shared float multiplier with an nd/rfd/rdy handshake. Sits between the channel-power stage and the position (delta/sigma) stage.

## Interface
Parameters:
- SF_WIDTH, 32, float word width; only 32 is supported.
- CNT_WIDTH, 16, width of the dropped-frame counter.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ChA_Gain_Corr, ChB_Gain_Corr, ChC_Gain_Corr, ChD_Gain_Corr  in  SF_WIDTH each  drift gain corrections (float).
- Corr_rdy  in  1  one-cycle strobe; the four Gain_Corr words are valid in this cycle.
- A_Pow, B_Pow, C_Pow, D_Pow  in  SF_WIDTH each  channel powers (float).
- data_valid  in  1  one-cycle strobe; the four Pow words are valid in this cycle.
- A_Pow_Corr, B_Pow_Corr, C_Pow_Corr, D_Pow_Corr  out  SF_WIDTH each  corrected powers. Reset value 0.
- Pow_Corr_rdy  out  1  one-cycle strobe; all four corrected outputs were updated this cycle. Reset value 0.
- busy  out  1  high in every state except IDLE. Reset value 0.
- drop_cnt  out  CNT_WIDTH  saturating count of rejected frames. Reset value 0.

## Operation
Gain registers:
- Pending set: written on every Corr_rdy. When Corr_rdy repeats before promotion, the last write wins. A pending_vld flag is set on write.
- Active set: the set used by the multiplier. Reset value is 1.0 (32'h3F800000) in all four channels.
- Promotion from pending to active happens only at frame acceptance. The four channels of one frame therefore always use one coherent gain set.
- Corr_rdy and data_valid in the same IDLE cycle: the Corr_rdy words go directly into the active set and are used for that frame.

States: IDLE, MUL_A, WAIT_A, MUL_B, WAIT_B, MUL_C, WAIT_C, MUL_D, WAIT_D, DONE.
- IDLE: Pow_Corr_rdy <= 0. On data_valid, latch A..D_Pow, promote pending gains if pending_vld, clear pending_vld, go to MUL_A.
- MUL_x: if rfd is high, load the operands (Pow_x, active gain_x), set nd <= 1, go to WAIT_x. If rfd is low, stay.
- WAIT_x: nd <= 0. On rdy, capture the result into the internal result register x. Then go to the next MUL state, or to DONE after WAIT_D.
- DONE: copy the four result registers to the outputs in the same cycle, Pow_Corr_rdy <= 1, go to IDLE.
- Outputs hold between DONE events. Partial results are never visible on the outputs.

Rules:
- Overrun: data_valid outside IDLE drops that frame. drop_cnt increments and saturates at all ones.
- Multiplier underflow, overflow and invalid flags are left unconnected. The result is passed through unchanged.
- Reset in any state: state goes to IDLE, nd goes to 0, pending_vld is cleared, active gains return to 1.0, all outputs take their reset values. A multiplier rdy in flight after reset is ignored because IDLE does not sample rdy.

## Timing
- Let L be the multiplier latency: rdy is high L cycles after the cycle in which nd is high. rfd is assumed high.
- data_valid is sampled in cycle 0. MUL_A is entered in cycle 1. MUL_x starts at cycle 1 + n(L+2), for n = 0..3. DONE is at cycle 4L+9.
- Pow_Corr_rdy is high in cycle 4L+10. With L = 6 that is cycle 34.
- Minimum frame period is 4L+10 cycles. A data_valid coincident with Pow_Corr_rdy, with the FSM back in IDLE, is accepted.
- A low rfd stretches MUL_x cycle-for-cycle. Latency grows by the number of stall cycles.

## Configuration
- DRIFT_GAIN_CLAMP_EN defined: each gain word is clamped as it enters the pending set.
  - The compare is an unsigned compare on the raw bits.
  - Sign bit set, or value below 32'h3F000000 (0.5), becomes 32'h3F000000.
  - Value above 32'h40000000 (2.0), including Inf and NaN, becomes 32'h40000000.
- DRIFT_GAIN_CLAMP_EN undefined: gains are stored unmodified.

## Structure
- Shared package drift_pkg holds:
  - the state enumeration;
  - SF_ONE = 32'h3F800000, SF_HALF = 32'h3F000000, SF_TWO = 32'h40000000.
- One sub-module, fp_mul_hs, wraps the float multiplier core. Its ports are a, b, operation_nd, operation_rfd, result, rdy. The bench substitutes a behavioural model with a configurable L and a controllable rfd.

## Test plan
- No Corr_rdy after reset, data_valid with A..D_Pow = 2.0, 3.0, 4.0, 5.0 -> in cycle 34 (L=6), Pow_Corr_rdy=1 and outputs are 2.0, 3.0, 4.0, 5.0 (unity gain).
- Corr_rdy with gains 0.5, 1.0, 1.5, 2.0, then data_valid with all Pow = 4.0 -> outputs 2.0, 4.0, 6.0, 8.0.
- Corr_rdy (gains 2.0) asserted during WAIT_B of frame 1 -> frame 1 uses the old gains on all four channels; frame 2 outputs are doubled.
- Three data_valid pulses during a busy frame -> drop_cnt = 3 and exactly one Pow_Corr_rdy.
- rst asserted in WAIT_C -> next cycle: busy=0, outputs 0, gains back to 1.0; a following frame completes correctly.
- With DRIFT_GAIN_CLAMP_EN, gains 32'h3E800000, 32'hBF800000, 32'h7FC00000, 32'h40400000 and Pow = 1.0 -> outputs 0.5, 0.5, 2.0, 2.0.

Source files
------------

// File: rtl/drift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : drift_pkg
// Purpose  : Shared types and float constants for the drift gain consumer.
// Revision : 1.0 - initial release
// ============================================================================
package drift_pkg;

  localparam logic [31:0] SF_ONE  = 32'h3F80_0000;
  localparam logic [31:0] SF_HALF = 32'h3F00_0000;
  localparam logic [31:0] SF_TWO  = 32'h4000_0000;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_MUL_A  = 4'd1,
    ST_WAIT_A = 4'd2,
    ST_MUL_B  = 4'd3,
    ST_WAIT_B = 4'd4,
    ST_MUL_C  = 4'd5,
    ST_WAIT_C = 4'd6,
    ST_MUL_D  = 4'd7,
    ST_WAIT_D = 4'd8,
    ST_DONE   = 4'd9
  } drift_state_e;

  // MUL/WAIT pairs are laid out consecutively, so the channel falls out of the code.
  function automatic logic [1:0] state_chan(drift_state_e s);
    logic [3:0] idx;
    idx = 4'(s) - 4'd1;
    return idx[2:1];
  endfunction

  function automatic logic [31:0] clamp_gain(logic [31:0] g);
    if (g[31] || (g < SF_HALF)) return SF_HALF;
    else if (g > SF_TWO)        return SF_TWO;
    else                        return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mul_hs.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_hs
// Purpose  : Pipelined single-precision multiplier with nd/rfd/rdy handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_hs #(
  parameter int LATENCY = 6
) (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        operation_nd,
  output logic        operation_rfd,
  output logic [31:0] result,
  output logic        rdy
);

  logic               s;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]        prod;
  logic [22:0]        frac;
  logic               guard, sticky, rnd;
  logic [23:0]        frac_r;
  logic signed [9:0]  e;
  logic [31:0]        prod_w;

  // Denormal inputs and results are flushed to zero; rounding is to nearest-even.
  always_comb begin
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    prod   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    if (prod[47]) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd    = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + 24'(rnd);
    e      = 10'(a[30:23]) + 10'(b[30:23]) - 10'sd127 + 10'(prod[47]) + 10'(frac_r[23]);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      prod_w = 32'h7FC0_0000;
    else if (a_inf || b_inf)
      prod_w = {s, 8'hFF, 23'd0};
    else if (a_zero || b_zero)
      prod_w = {s, 31'd0};
    else if (e >= 10'sd255)
      prod_w = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      prod_w = {s, 31'd0};
    else
      prod_w = {s, e[7:0], frac_r[22:0]};
  end

  logic [LATENCY-1:0][31:0] res_d, res_q;
  logic [LATENCY-1:0]       vld_d, vld_q;

  always_comb begin
    res_d[0] = prod_w;
    vld_d[0] = operation_nd;
    for (int i = 1; i < LATENCY; i++) begin
      res_d[i] = res_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    res_q <= res_d;
    vld_q <= vld_d;
  end

  assign operation_rfd = 1'b1;
  assign result        = res_q[LATENCY-1];
  assign rdy           = vld_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/drift_corr_apply.sv
`default_nettype none
// ============================================================================
// Module   : drift_corr_apply
// Purpose  : Applies latched drift gain corrections to 4-channel power frames.
//            Optional gain clamping to [0.5, 2.0]: define DRIFT_GAIN_CLAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module drift_corr_apply
  import drift_pkg::*;
#(
  parameter int SF_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SF_WIDTH-1:0]  ChA_Gain_Corr,
  input  logic [SF_WIDTH-1:0]  ChB_Gain_Corr,
  input  logic [SF_WIDTH-1:0]  ChC_Gain_Corr,
  input  logic [SF_WIDTH-1:0]  ChD_Gain_Corr,
  input  logic                 Corr_rdy,
  input  logic [SF_WIDTH-1:0]  A_Pow,
  input  logic [SF_WIDTH-1:0]  B_Pow,
  input  logic [SF_WIDTH-1:0]  C_Pow,
  input  logic [SF_WIDTH-1:0]  D_Pow,
  input  logic                 data_valid,
  output logic [SF_WIDTH-1:0]  A_Pow_Corr,
  output logic [SF_WIDTH-1:0]  B_Pow_Corr,
  output logic [SF_WIDTH-1:0]  C_Pow_Corr,
  output logic [SF_WIDTH-1:0]  D_Pow_Corr,
  output logic                 Pow_Corr_rdy,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  drift_state_e              state_q, state_d;
  logic                      nd_q, nd_d;
  logic [SF_WIDTH-1:0]       opa_q, opa_d, opb_q, opb_d;
  logic [3:0][SF_WIDTH-1:0]  pow_q, pow_d, act_q, act_d, pend_q, pend_d;
  logic [3:0][SF_WIDTH-1:0]  res_q, res_d, out_q, out_d;
  logic                      pend_vld_q, pend_vld_d;
  logic                      pcr_q, pcr_d;
  logic [CNT_WIDTH-1:0]      drop_q, drop_d;
  logic [3:0][SF_WIDTH-1:0]  gain_in;
  logic [1:0]                ch;
  logic                      mul_rfd, mul_rdy;
  logic [SF_WIDTH-1:0]       mul_result;

`ifdef DRIFT_GAIN_CLAMP_EN
  assign gain_in = {clamp_gain(ChD_Gain_Corr), clamp_gain(ChC_Gain_Corr),
                    clamp_gain(ChB_Gain_Corr), clamp_gain(ChA_Gain_Corr)};
`else
  assign gain_in = {ChD_Gain_Corr, ChC_Gain_Corr, ChB_Gain_Corr, ChA_Gain_Corr};
`endif

  assign ch = state_chan(state_q);

  fp_mul_hs #(.LATENCY(6)) u_mul (
    .clk           (clk),
    .a             (opa_q),
    .b             (opb_q),
    .operation_nd  (nd_q),
    .operation_rfd (mul_rfd),
    .result        (mul_result),
    .rdy           (mul_rdy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      nd_q       <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      pow_q      <= '0;
      act_q      <= {4{SF_ONE}};
      pend_q     <= {4{SF_ONE}};
      pend_vld_q <= 1'b0;
      res_q      <= '0;
      out_q      <= '0;
      pcr_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      nd_q       <= nd_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      pow_q      <= pow_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      res_q      <= res_d;
      out_q      <= out_d;
      pcr_q      <= pcr_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (data_valid) state_d = ST_MUL_A;
      ST_MUL_A:  if (mul_rfd)    state_d = ST_WAIT_A;
      ST_WAIT_A: if (mul_rdy)    state_d = ST_MUL_B;
      ST_MUL_B:  if (mul_rfd)    state_d = ST_WAIT_B;
      ST_WAIT_B: if (mul_rdy)    state_d = ST_MUL_C;
      ST_MUL_C:  if (mul_rfd)    state_d = ST_WAIT_C;
      ST_WAIT_C: if (mul_rdy)    state_d = ST_MUL_D;
      ST_MUL_D:  if (mul_rfd)    state_d = ST_WAIT_D;
      ST_WAIT_D: if (mul_rdy)    state_d = ST_DONE;
      ST_DONE:                   state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    nd_d       = 1'b0;
    opa_d      = opa_q;
    opb_d      = opb_q;
    pow_d      = pow_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    res_d      = res_q;
    out_d      = out_q;
    pcr_d      = 1'b0;
    drop_d     = drop_q;

    if (Corr_rdy) begin
      pend_d     = gain_in;
      pend_vld_d = 1'b1;
    end

    // Gains are promoted only at acceptance so a frame never mixes two gain sets.
    if (data_valid) begin
      if (state_q == ST_IDLE) begin
        pow_d = {D_Pow, C_Pow, B_Pow, A_Pow};
        if (Corr_rdy) begin
          act_d      = gain_in;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          act_d      = pend_q;
          pend_vld_d = 1'b0;
        end
      end else if (drop_q != {CNT_WIDTH{1'b1}}) begin
        drop_d = drop_q + CNT_WIDTH'(1);
      end
    end

    case (state_q)
      ST_MUL_A, ST_MUL_B, ST_MUL_C, ST_MUL_D: begin
        if (mul_rfd) begin
          opa_d = pow_q[ch];
          opb_d = act_q[ch];
          nd_d  = 1'b1;
        end
      end
      ST_WAIT_A, ST_WAIT_B, ST_WAIT_C, ST_WAIT_D: begin
        if (mul_rdy) res_d[ch] = mul_result;
      end
      ST_DONE: begin
        out_d = res_q;
        pcr_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign A_Pow_Corr   = out_q[0];
  assign B_Pow_Corr   = out_q[1];
  assign C_Pow_Corr   = out_q[2];
  assign D_Pow_Corr   = out_q[3];
  assign Pow_Corr_rdy = pcr_q;
  assign busy         = (state_q != ST_IDLE);
  assign drop_cnt     = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_drift_corr_apply.sv
`default_nettype none
// ============================================================================
// Module   : tb_drift_corr_apply
// Purpose  : Directed self-checking bench for drift_corr_apply (L = 6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_drift_corr_apply;

  localparam logic [31:0] F0_5 = 32'h3F00_0000, F1_0 = 32'h3F80_0000, F1_5 = 32'h3FC0_0000;
  localparam logic [31:0] F2_0 = 32'h4000_0000, F3_0 = 32'h4040_0000, F4_0 = 32'h4080_0000;
  localparam logic [31:0] F4_5 = 32'h4090_0000, F5_0 = 32'h40A0_0000, F6_0 = 32'h40C0_0000;
  localparam logic [31:0] F7_5 = 32'h40F0_0000, F8_0 = 32'h4100_0000, F10_0 = 32'h4120_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ga = '0, gb = '0, gc = '0, gd = '0;
  logic        corr_rdy = 1'b0;
  logic [31:0] pa = '0, pb = '0, pc = '0, pd = '0;
  logic        dv = 1'b0;
  logic [31:0] oa, ob, oc, od;
  logic        pcr, busy;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  drift_corr_apply #(.SF_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .ChA_Gain_Corr(ga), .ChB_Gain_Corr(gb), .ChC_Gain_Corr(gc), .ChD_Gain_Corr(gd),
    .Corr_rdy(corr_rdy),
    .A_Pow(pa), .B_Pow(pb), .C_Pow(pc), .D_Pow(pd),
    .data_valid(dv),
    .A_Pow_Corr(oa), .B_Pow_Corr(ob), .C_Pow_Corr(oc), .D_Pow_Corr(od),
    .Pow_Corr_rdy(pcr), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e0, e1, e2, e3);
    chk({tag, ".A"}, oa, e0);
    chk({tag, ".B"}, ob, e1);
    chk({tag, ".C"}, oc, e2);
    chk({tag, ".D"}, od, e3);
  endtask

  task automatic set_gains(input logic [31:0] g0, g1, g2, g3);
    ga = g0; gb = g1; gc = g2; gd = g3;
    corr_rdy = 1'b1;
    tick();
    corr_rdy = 1'b0;
  endtask

  // Presents a frame in the current cycle (cycle 0) and returns in cycle 1.
  task automatic start_frame(input logic [31:0] p0, p1, p2, p3);
    pa = p0; pb = p1; pc = p2; pd = p3;
    dv = 1'b1;
    tick();
    dv = 1'b0;
  endtask

  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (!pcr && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int n_pulse;
  int pulse_cyc;
  logic [31:0] cap_a, cap_d;

  initial begin
    // Reset state
    tick(); tick(); tick();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.pcr", 32'(pcr), 32'd0);
    chk("rst.out_a", oa, 32'd0);
    chk("rst.drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Unity gain after reset
    start_frame(F2_0, F3_0, F4_0, F5_0);
    wait_done(1, lat);
    chk("unity.lat", 32'(lat), 32'd34);
    chk_out("unity", F2_0, F3_0, F4_0, F5_0);
    tick();
    chk("unity.strobe_once", 32'(pcr), 32'd0);

    // Pending gains promoted on next frame
    set_gains(F0_5, F1_0, F1_5, F2_0);
    tick();
    start_frame(F4_0, F4_0, F4_0, F4_0);
    wait_done(1, lat);
    chk("gain.lat", 32'(lat), 32'd34);
    chk_out("gain", F2_0, F4_0, F6_0, F8_0);

    // New gains arriving in WAIT_B must not touch the in-flight frame
    tick();
    start_frame(F2_0, F3_0, F4_0, F5_0);
    repeat (10) tick();
    chk("midframe.busy", 32'(busy), 32'd1);
    set_gains(F2_0, F2_0, F2_0, F2_0);
    wait_done(12, lat);
    chk("coherent.lat", 32'(lat), 32'd34);
    chk_out("coherent", F1_0, F3_0, F6_0, F10_0);
    tick();
    start_frame(F2_0, F3_0, F4_0, F5_0);
    wait_done(1, lat);
    chk_out("doubled", F4_0, F6_0, F8_0, F10_0);

    // Corr_rdy and data_valid in the same IDLE cycle
    tick();
    ga = F1_5; gb = F1_5; gc = F1_5; gd = F1_5;
    corr_rdy = 1'b1;
    start_frame(F2_0, F3_0, F4_0, F5_0);
    corr_rdy = 1'b0;
    wait_done(1, lat);
    chk_out("simul", F3_0, F4_5, F6_0, F7_5);

    // Frame presented in the Pow_Corr_rdy cycle is accepted
    start_frame(F4_0, F4_0, F4_0, F4_0);
    wait_done(1, lat);
    chk("b2b.lat", 32'(lat), 32'd34);
    chk_out("b2b", F6_0, F6_0, F6_0, F6_0);
    chk("b2b.drop", 32'(drop_cnt), 32'd0);

    // Overrun: three frames dropped while busy
    tick();
    start_frame(F1_0, F1_0, F1_0, F1_0);
    n_pulse = 0; pulse_cyc = 0; cap_a = '0; cap_d = '0;
    pa = F8_0; pb = F8_0; pc = F8_0; pd = F8_0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (pcr) begin
        n_pulse++;
        pulse_cyc = cyc;
        cap_a = oa;
        cap_d = od;
      end
      dv = (cyc == 5 || cyc == 10 || cyc == 20);
      tick();
    end
    dv = 1'b0;
    chk("ovr.pulses", 32'(n_pulse), 32'd1);
    chk("ovr.pulse_cyc", 32'(pulse_cyc), 32'd34);
    chk("ovr.drop", 32'(drop_cnt), 32'd3);
    chk("ovr.out_a", cap_a, F1_5);
    chk("ovr.out_d", cap_d, F1_5);

    // Reset in WAIT_C with a pending gain set outstanding
    start_frame(F1_0, F1_0, F1_0, F1_0);
    repeat (3) tick();
    set_gains(F2_0, F2_0, F2_0, F2_0);
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2.busy", 32'(busy), 32'd0);
    chk("rst2.pcr", 32'(pcr), 32'd0);
    chk_out("rst2", 32'd0, 32'd0, 32'd0, 32'd0);
    chk("rst2.drop", 32'(drop_cnt), 32'd0);
    repeat (10) tick();
    start_frame(F2_0, F3_0, F4_0, F5_0);
    wait_done(1, lat);
    chk("post_rst.lat", 32'(lat), 32'd34);
    chk_out("post_rst", F2_0, F3_0, F4_0, F5_0);

    // Out-of-range gains
    tick();
    set_gains(32'h3E80_0000, 32'hBF80_0000, 32'h7FC0_0000, 32'h4040_0000);
    tick();
    start_frame(F1_0, F1_0, F1_0, F1_0);
    wait_done(1, lat);
`ifdef DRIFT_GAIN_CLAMP_EN
    chk_out("clamp", F0_5, F0_5, F2_0, F2_0);
`else
    chk_out("noclamp", 32'h3E80_0000, 32'hBF80_0000, 32'h7FC0_0000, 32'h4040_0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
